// File: rtl/pair_mac_accumulator.sv
// Pair MAC accumulator: sums unsigned a*b products over a frame
// and presents sum, beat count and overflow on a registered output.
module pair_mac_accumulator #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] odata_q, odata_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;
  logic             oovf_q, oovf_d;
  logic             ovld_q, ovld_d;

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W:0]      sum;
  logic                beat;
  logic                first;
  logic [ACC_W-1:0]    acc_nx;
  logic [CNT_W-1:0]    cnt_nx;
  logic                ovf_nx;
  logic                close;

  assign in_ready = !rst && (state_q != HOLD);
  assign beat     = in_valid && in_ready;

  assign prod     = in_a * in_b;
  assign prod_ext = ACC_W'(prod);
  assign sum      = {1'b0, acc_q} + {1'b0, prod_ext};

  // Values the frame would hold after accepting this beat
  assign first  = (state_q == IDLE);
  assign acc_nx = first ? prod_ext : sum[ACC_W-1:0];
  assign cnt_nx = first ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign ovf_nx = first ? 1'b0 : (ovf_q | sum[ACC_W]);
  assign close  = in_last || (cnt_nx == CNT_W'(MAX_LEN));

  // Next-state and result capture
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    odata_d = odata_q;
    ocnt_d  = ocnt_q;
    oovf_d  = oovf_q;
    ovld_d  = ovld_q;
    unique case (state_q)
      IDLE, ACC: begin
        if (beat) begin
          acc_d = acc_nx;
          cnt_d = cnt_nx;
          ovf_d = ovf_nx;
          if (close) begin
            odata_d = acc_nx;
            ocnt_d  = cnt_nx;
            oovf_d  = ovf_nx;
            ovld_d  = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = ACC;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          ovld_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      odata_q <= '0;
      ocnt_q  <= '0;
      oovf_q  <= 1'b0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      odata_q <= odata_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
      ovld_q  <= ovld_d;
    end
  end

  assign out_valid    = ovld_q;
  assign out_data     = odata_q;
  assign out_count    = ocnt_q;
  assign out_overflow = oovf_q;

endmodule
